bf_jump_ctrl: RTL and testbench

Bracket-matching jump sequencer for the BF machine datapath. When the main control FSM decodes `[` with a zero data cell, or `]` with a nonzero cell, it hands the program counter to this block, which steps PC through program memory one instruction at a time, tracks bracket nesting depth, and stops with PC resting on the matching bracket. It then returns control with a one-cycle `done` pulse, or with `err` if no match is found within the step budget. It drives the PC load/direction controls that feed `PCALU`/`PC`, and reads the 4-bit `pmemory2` output.

---
 rtl/bf_jump_ctrl.sv | 112 +++++++++++
 tb/tb_bf_jump_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bf_jump_ctrl.sv
// Bracket-matching jump sequencer: steps PC one instruction at a time until the
// matching bracket is found, then pulses done (or err on budget/depth overflow).
module bf_jump_ctrl #(
  parameter logic [3:0] OP_OPEN   = 4'd6,
  parameter logic [3:0] OP_CLOSE  = 4'd7,
  parameter int         DEPTH_W   = 8,
  parameter int         MAX_STEPS = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] pm_q,
  output logic       pc_step,
  output logic       pc_dec,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STEP  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [7:0]         MAX_STEPS_C = 8'(MAX_STEPS);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE   = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL  = '1;

  logic [2:0]         state_q, state_d;
  logic               dir_q, dir_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [7:0]         steps_q, steps_d;

  logic               is_nest, is_unnest, budget_spent;

  // Searching forward from '[' nests on '[' and un-nests on ']'; backward is the mirror.
  assign is_nest      = (pm_q == (dir_q ? OP_CLOSE : OP_OPEN));
  assign is_unnest    = (pm_q == (dir_q ? OP_OPEN : OP_CLOSE));
  assign budget_spent = (steps_q == MAX_STEPS_C);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no branch can infer a latch.
    state_d = state_q;
    dir_d   = dir_q;
    depth_d = depth_q;
    steps_d = steps_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          depth_d = DEPTH_ONE;
          steps_d = '0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        steps_d = steps_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (is_unnest) begin
          depth_d = depth_q - DEPTH_ONE;
          if (depth_q == DEPTH_ONE) state_d = S_DONE;
          else if (budget_spent)    state_d = S_ERR;
          else                      state_d = S_STEP;
        end else if (is_nest) begin
          // Saturated depth aborts without touching the counter.
          if (depth_q == DEPTH_FULL) begin
            state_d = S_ERR;
          end else begin
            depth_d = depth_q + DEPTH_ONE;
            state_d = budget_spent ? S_ERR : S_STEP;
          end
        end else begin
          state_d = budget_spent ? S_ERR : S_STEP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      depth_q <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      depth_q <= depth_d;
      steps_q <= steps_d;
    end
  end

  assign pc_step = (state_q == S_STEP);
  assign done    = (state_q == S_DONE);
  assign err     = (state_q == S_ERR);
  assign busy    = (state_q != S_IDLE);
  assign pc_dec  = dir_q;

endmodule

// File: tb/tb_bf_jump_ctrl.sv
// Directed bench for bf_jump_ctrl with a PC/program-memory model and a
// scoreboard of expected search outcomes (kind, cycle, final PC).
module tb_bf_jump_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  always #5 clock = ~clock;

  logic       start_a = 1'b0, dir_a = 1'b0, start_b = 1'b0, dir_b = 1'b0;
  logic [3:0] pm_q_a, pm_q_b;
  logic       pc_step_a, pc_dec_a, busy_a, done_a, err_a;
  logic       pc_step_b, pc_dec_b, busy_b, done_b, err_b;

  logic [3:0] mem [256];
  logic [7:0] pc_a, pc_b, pc_load_val = 8'd0;
  logic       pc_load_a = 1'b0, pc_load_b = 1'b0;

  // PC register plus synchronous program memory, one per DUT instance.
  always @(posedge clock) begin
    if (pc_load_a)      pc_a <= pc_load_val;
    else if (pc_step_a) pc_a <= pc_dec_a ? pc_a - 8'd1 : pc_a + 8'd1;
    pm_q_a <= mem[pc_a];
    if (pc_load_b)      pc_b <= pc_load_val;
    else if (pc_step_b) pc_b <= pc_dec_b ? pc_b - 8'd1 : pc_b + 8'd1;
    pm_q_b <= mem[pc_b];
  end

  bf_jump_ctrl u_dut_a (
    .clock(clock), .reset(reset), .start(start_a), .dir(dir_a), .pm_q(pm_q_a),
    .pc_step(pc_step_a), .pc_dec(pc_dec_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  bf_jump_ctrl #(.DEPTH_W(2)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b), .dir(dir_b), .pm_q(pm_q_b),
    .pc_step(pc_step_b), .pc_dec(pc_dec_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  logic       sel = 1'b0;
  logic       obs_step, obs_dec, obs_busy, obs_done, obs_err;
  logic [7:0] obs_pc;
  assign obs_step = sel ? pc_step_b : pc_step_a;
  assign obs_dec  = sel ? pc_dec_b  : pc_dec_a;
  assign obs_busy = sel ? busy_b    : busy_a;
  assign obs_done = sel ? done_b    : done_a;
  assign obs_err  = sel ? err_b     : err_a;
  assign obs_pc   = sel ? pc_b      : pc_a;

  typedef struct {
    string      tag;
    bit         is_err;
    int         cyc;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic fill(input logic [3:0] v);
    foreach (mem[i]) mem[i] = v;
  endtask

  task automatic set_in(input bit b, input logic s, input logic d);
    if (b) begin start_b = s; dir_b = d; end
    else   begin start_a = s; dir_a = d; end
  endtask

  // Load PC and start in the same cycle (cycle 0), then watch cycles 1..exp_cyc+1.
  task automatic run_search(input string tag, input bit b, input logic [7:0] pc0, input logic d,
                            input bit exp_err, input int exp_cyc, input logic [7:0] exp_pc,
                            input int pulse_at);
    exp_t e, got;
    bit   seen = 1'b0;
    int   bad_busy = 0, bad_step = 0, bad_dec = 0, bad_term = 0;
    e.tag = tag; e.is_err = exp_err; e.cyc = exp_cyc; e.pc = exp_pc;
    exp_q.push_back(e);
    sel = b;
    @(negedge clock);
    pc_load_val = pc0;
    if (b) pc_load_b = 1'b1; else pc_load_a = 1'b1;
    set_in(b, 1'b1, d);
    for (int c = 1; c <= exp_cyc + 1; c++) begin
      @(negedge clock);
      pc_load_a = 1'b0;
      pc_load_b = 1'b0;
      set_in(b, c == pulse_at, (c == pulse_at) ? ~d : d);
      if (obs_busy !== (c <= exp_cyc)) bad_busy++;
      if (obs_step !== (c < exp_cyc && (c % 3) == 1)) bad_step++;
      if (obs_busy && obs_dec !== d) bad_dec++;
      if (obs_done !== (c == exp_cyc && !exp_err)) bad_term++;
      if (obs_err  !== (c == exp_cyc && exp_err))  bad_term++;
      if ((obs_done || obs_err) && !seen) begin
        seen = 1'b1;
        got  = exp_q.pop_front();
        check({got.tag, " kind_err"}, obs_err, got.is_err);
        check({got.tag, " cycle"}, c, got.cyc);
        check({got.tag, " final_pc"}, obs_pc, got.pc);
      end
    end
    check({tag, " terminal_seen"}, seen, 1);
    if (!seen) void'(exp_q.pop_front());
    check({tag, " busy_pattern_bad"}, bad_busy, 0);
    check({tag, " step_pattern_bad"}, bad_step, 0);
    check({tag, " dec_pattern_bad"}, bad_dec, 0);
    check({tag, " term_pulse_bad"}, bad_term, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;

    // Reset state of both instances.
    repeat (2) @(negedge clock);
    check("rst pc_step_a", pc_step_a, 0);
    check("rst busy_a", busy_a, 0);
    check("rst done_a", done_a, 0);
    check("rst err_a", err_a, 0);
    check("rst pc_dec_a", pc_dec_a, 0);
    check("rst busy_b", busy_b, 0);
    check("rst pc_step_b", pc_step_b, 0);
    check("rst err_b", err_b, 0);
    reset = 1'b1;
    @(negedge clock);

    // [ + ]
    fill(4'd2);
    mem[0] = 4'd6; mem[1] = 4'd2; mem[2] = 4'd7;
    run_search("fwd_simple", 1'b0, 8'd0, 1'b0, 1'b0, 7, 8'd2, -1);
    run_search("start_while_busy", 1'b0, 8'd0, 1'b0, 1'b0, 7, 8'd2, 3);

    // [ [ - ] ]
    fill(4'd2);
    mem[0] = 4'd6; mem[1] = 4'd6; mem[2] = 4'd3; mem[3] = 4'd7; mem[4] = 4'd7;
    run_search("fwd_nested", 1'b0, 8'd0, 1'b0, 1'b0, 13, 8'd4, -1);
    run_search("backward", 1'b0, 8'd4, 1'b1, 1'b0, 13, 8'd0, -1);
    check("pc_dec latched in idle", pc_dec_a, 1);

    // Four nested '[' overflow a 2-bit depth counter.
    fill(4'd2);
    mem[0] = 4'd6; mem[1] = 4'd6; mem[2] = 4'd6; mem[3] = 4'd6;
    run_search("depth_overflow", 1'b1, 8'd0, 1'b0, 1'b1, 10, 8'd3, -1);

    // '[' followed by 255 non-brackets exhausts the step budget.
    fill(4'd2);
    mem[0] = 4'd6;
    run_search("unmatched", 1'b0, 8'd0, 1'b0, 1'b1, 766, 8'd255, -1);

    // Reset mid-search in cycle 5 of a forward search.
    fill(4'd2);
    mem[0] = 4'd6; mem[1] = 4'd2; mem[2] = 4'd7;
    sel = 1'b0;
    @(negedge clock);
    pc_load_val = 8'd0;
    pc_load_a   = 1'b1;
    set_in(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      pc_load_a = 1'b0;
      set_in(1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    #1;
    check("midrst busy", busy_a, 0);
    check("midrst pc_step", pc_step_a, 0);
    check("midrst done", done_a, 0);
    check("midrst err", err_a, 0);
    check("midrst pc_dec", pc_dec_a, 0);
    check("midrst pc_held", pc_a, 8'd2);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (pc_step_a !== 1'b0 || busy_a !== 1'b0) stray++;
    end
    check("post_rst stray_activity", stray, 0);
    check("post_rst pc_unchanged", pc_a, 8'd2);
    run_search("after_reset", 1'b0, 8'd0, 1'b0, 1'b0, 7, 8'd2, -1);

    check("scoreboard empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
